player_input_arbiter: RTL and testbench

Front-end for the four hand-held controllers on the GPIO header. It synchronizes and debounces each player's buzz button and synchronizes the 8-bit answer switches. It decides which player buzzed first and latches that player's answer. The results drive the player-input I/O registers read by the CPU through the memory-mapped I/O space.

---
 rtl/player_input_arbiter.sv | 143 ++++++++++++++
 tb/tb_player_input_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/player_input_arbiter.sv
// Buzzer front-end for four controllers: synchronizes all pins, debounces the buzz
// buttons, picks the first player to buzz and latches that player's answer byte.
module player_input_arbiter #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [35:0] gpins,
   input  logic        clear,
   output logic [7:0]  playerInput,
   output logic        playerInputFlag,
   output logic [3:0]  firstPlayerFlag,
   output logic [3:0]  buttons
);

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ARMED        = 2'd0,
      LOCKED       = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   logic [35:0]       meta_q, meta_d;
   logic [35:0]       sync_q, sync_d;
   logic [3:0][15:0]  cnt_q, cnt_d;
   logic [3:0]        db_q, db_d;
   logic [3:0]        db_prev_q, db_prev_d;

   logic [3:0]        btn_sync;
   logic [3:0][7:0]   sw_sync;
   logic [3:0]        press;
   logic [3:0]        win_onehot;
   logic [1:0]        win_idx;

   state_t            state_q;
   logic [7:0]        player_input_q;
   logic              flag_q;
   logic [3:0]        first_q;

   always_comb begin
      meta_d = gpins;
      sync_d = meta_q;
   end

   always_comb begin
      btn_sync = '0;
      sw_sync  = '0;
      for (int p = 0; p < 4; p++) begin
         btn_sync[p] = sync_q[9*p + 8];
         sw_sync[p]  = sync_q[9*p +: 8];
      end
   end

   // The counter only runs while the synced level disagrees with the debounced one,
   // so a single agreeing sample restarts the stability window.
   always_comb begin
      cnt_d     = cnt_q;
      db_d      = db_q;
      db_prev_d = db_q;
      for (int p = 0; p < 4; p++) begin
         if (btn_sync[p] == db_q[p]) begin
            cnt_d[p] = '0;
         end else if (cnt_q[p] == DB_LAST) begin
            db_d[p]  = btn_sync[p];
            cnt_d[p] = '0;
         end else begin
            cnt_d[p] = cnt_q[p] + 16'd1;
         end
      end
   end

   always_comb begin
      press      = db_q & ~db_prev_q;
      win_onehot = press & (~press + 4'd1);
      win_idx    = 2'd0;
      for (int p = 3; p >= 0; p--) begin
         if (press[p]) begin
            win_idx = 2'(p);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q    <= '0;
         sync_q    <= '0;
         cnt_q     <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
      end else begin
         meta_q    <= meta_d;
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
      end
   end

   // Press events are only honoured in ARMED; WAIT_RELEASE keeps a still-held
   // button from winning again straight after a clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ARMED;
         player_input_q <= '0;
         flag_q         <= 1'b0;
         first_q        <= '0;
      end else begin
         case (state_q)
            ARMED: begin
               if (|press) begin
                  first_q        <= win_onehot;
                  player_input_q <= sw_sync[win_idx];
                  flag_q         <= 1'b1;
                  state_q        <= LOCKED;
               end
            end
            LOCKED: begin
               if (clear) begin
                  first_q        <= '0;
                  player_input_q <= '0;
                  flag_q         <= 1'b0;
                  state_q        <= (|db_q) ? WAIT_RELEASE : ARMED;
               end
            end
            WAIT_RELEASE: begin
               if (db_q == 4'd0) begin
                  state_q <= ARMED;
               end
            end
            default: begin
               state_q <= ARMED;
            end
         endcase
      end
   end

   assign playerInput     = player_input_q;
   assign playerInputFlag = flag_q;
   assign firstPlayerFlag = first_q;
   assign buttons         = db_q;

endmodule

// File: tb/tb_player_input_arbiter.sv
// Directed bench for player_input_arbiter with DEBOUNCE_CYCLES = 4; expected values
// are hand-derived from the edge timing of synchronizer, debouncer and FSM.
module tb_player_input_arbiter;

   logic        clk;
   logic        rst;
   logic [35:0] gpins;
   logic        clear;
   logic [7:0]  playerInput;
   logic        playerInputFlag;
   logic [3:0]  firstPlayerFlag;
   logic [3:0]  buttons;

   int error_count = 0;
   int check_count = 0;

   player_input_arbiter #(.DEBOUNCE_CYCLES(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .gpins           (gpins),
      .clear           (clear),
      .playerInput     (playerInput),
      .playerInputFlag (playerInputFlag),
      .firstPlayerFlag (firstPlayerFlag),
      .buttons         (buttons)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Advance n active edges, leaving time 1 unit past the last edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input int p, input logic btn, input logic [7:0] sw);
      gpins[9*p + 8]  = btn;
      gpins[9*p +: 8] = sw;
   endtask

   task automatic setButton(input int p, input logic btn);
      gpins[9*p + 8] = btn;
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_flag"},  32'(playerInputFlag), 32'd0);
      checkOutput({tag, "_first"}, 32'(firstPlayerFlag), 32'd0);
      checkOutput({tag, "_pi"},    32'(playerInput),     32'd0);
   endtask

   initial begin
      rst   = 1'b0;
      gpins = '0;
      clear = 1'b0;
      step(3);
      rst = 1'b1;
      step(2);

      // Reset mid-count with player 1 held
      applyStimulus(1, 1'b1, 8'h3C);
      step(3);
      rst = 1'b0;
      #2;
      checkIdle("rst_async");
      checkOutput("rst_buttons", 32'(buttons), 32'd0);
      step(2);
      checkIdle("rst_hold");
      rst = 1'b1;
      step(6);
      checkOutput("rst_btn_e5", 32'(buttons), 32'h2);
      checkOutput("rst_flag_e5", 32'(playerInputFlag), 32'd0);
      step(1);
      checkOutput("rst_flag_e6", 32'(playerInputFlag), 32'd1);
      checkOutput("rst_first", 32'(firstPlayerFlag), 32'h2);
      checkOutput("rst_pi", 32'(playerInput), 32'h3C);
      setButton(1, 1'b0);
      step(8);
      checkOutput("rst_rel_btn", 32'(buttons), 32'd0);
      checkOutput("rst_hold_flag", 32'(playerInputFlag), 32'd1);
      pulseClear();
      checkIdle("rst_clr");

      // Single winner, player 2
      applyStimulus(2, 1'b1, 8'hA5);
      step(5);
      checkOutput("sw_btn_e4", 32'(buttons), 32'd0);
      step(1);
      checkOutput("sw_btn_e5", 32'(buttons), 32'h4);
      checkOutput("sw_flag_e5", 32'(playerInputFlag), 32'd0);
      step(1);
      checkOutput("sw_flag_e6", 32'(playerInputFlag), 32'd1);
      checkOutput("sw_first", 32'(firstPlayerFlag), 32'h4);
      checkOutput("sw_pi", 32'(playerInput), 32'hA5);
      applyStimulus(2, 1'b1, 8'h5A);
      step(3);
      checkOutput("sw_pi_hold", 32'(playerInput), 32'hA5);
      setButton(2, 1'b0);
      step(8);
      pulseClear();
      checkIdle("sw_clr");

      // Tie between players 1 and 3
      applyStimulus(1, 1'b1, 8'h11);
      applyStimulus(3, 1'b1, 8'h33);
      step(7);
      checkOutput("tie_first", 32'(firstPlayerFlag), 32'h2);
      checkOutput("tie_pi", 32'(playerInput), 32'h11);
      setButton(3, 1'b0);
      step(8);
      checkOutput("tie_rel_btn", 32'(buttons), 32'h2);
      setButton(3, 1'b1);
      step(8);
      checkOutput("tie_repress_btn", 32'(buttons), 32'hA);
      checkOutput("tie_repress_first", 32'(firstPlayerFlag), 32'h2);
      checkOutput("tie_repress_pi", 32'(playerInput), 32'h11);
      setButton(1, 1'b0);
      setButton(3, 1'b0);
      step(8);
      pulseClear();
      checkIdle("tie_clr");

      // Glitch rejection on player 0, then a 4-cycle pulse that locks
      applyStimulus(0, 1'b1, 8'h0F);
      step(3);
      setButton(0, 1'b0);
      step(10);
      checkOutput("gl_btn", 32'(buttons), 32'd0);
      checkOutput("gl_flag", 32'(playerInputFlag), 32'd0);
      setButton(0, 1'b1);
      step(4);
      setButton(0, 1'b0);
      step(4);
      checkOutput("gl4_flag", 32'(playerInputFlag), 32'd1);
      checkOutput("gl4_first", 32'(firstPlayerFlag), 32'h1);
      checkOutput("gl4_pi", 32'(playerInput), 32'h0F);
      step(10);
      checkOutput("gl4_rel_btn", 32'(buttons), 32'd0);
      pulseClear();
      checkIdle("gl_clr");

      // Clear while player 1 still holds
      applyStimulus(1, 1'b1, 8'h77);
      step(7);
      checkOutput("ch_first", 32'(firstPlayerFlag), 32'h2);
      pulseClear();
      checkIdle("ch_clr");
      applyStimulus(0, 1'b1, 8'hC3);
      step(10);
      checkOutput("ch_wait_btn", 32'(buttons), 32'h3);
      checkIdle("ch_wait");
      setButton(0, 1'b0);
      setButton(1, 1'b0);
      step(8);
      checkOutput("ch_rel_btn", 32'(buttons), 32'd0);
      checkIdle("ch_rel");
      setButton(0, 1'b1);
      step(7);
      checkOutput("ch_new_flag", 32'(playerInputFlag), 32'd1);
      checkOutput("ch_new_first", 32'(firstPlayerFlag), 32'h1);
      checkOutput("ch_new_pi", 32'(playerInput), 32'hC3);

      // Clear after release, then clear in ARMED
      setButton(0, 1'b0);
      step(10);
      checkOutput("cr_hold_flag", 32'(playerInputFlag), 32'd1);
      pulseClear();
      checkIdle("cr_clr");
      pulseClear();
      checkIdle("cr_armed_clr");
      applyStimulus(2, 1'b1, 8'h9E);
      step(7);
      checkOutput("cr_new_flag", 32'(playerInputFlag), 32'd1);
      checkOutput("cr_new_first", 32'(firstPlayerFlag), 32'h4);
      checkOutput("cr_new_pi", 32'(playerInput), 32'h9E);

      $display("Result: errors=%0d of %0d checks", error_count, check_count);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
